// File: rtl/irq_ack_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ack_decoder
//  Purpose  : Return path for the interrupt priority encoder. Buffers encoded
//             request indices in a small FIFO, decodes each one to a one-hot
//             acknowledge line and holds it until the serviced source reports
//             done, with a guaranteed minimum hold time.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ack_decoder #(
  parameter int IDX_W    = 2,
  parameter int DEPTH    = 2,
  parameter int MIN_HOLD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [IDX_W-1:0]        in_index,
  output logic                    in_ready,
  output logic [(2**IDX_W)-1:0]   ack_onehot,
  output logic                    ack_valid,
  input  logic                    done_in,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int OUT_W = 2**IDX_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(MIN_HOLD) + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   mem_q [DEPTH];
  logic [IDX_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_seen_q, done_seen_d;
  logic [OUT_W-1:0]   ack_onehot_q, ack_onehot_d;
  logic               ack_valid_q, ack_valid_d;

  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [IDX_W-1:0]   w_head;

  // Handshake and FIFO control; in_ready only looks at registered occupancy,
  // so a pop in the same cycle never opens a full FIFO (no bypass path).
  always_comb begin
    w_full   = (level_q == LVL_W'(DEPTH));
    in_ready = !rst && !w_full;
    w_push   = in_valid && in_ready;
    w_pop    = (state_q == ST_IDLE) && (level_q != '0);
    w_head   = mem_q[rd_ptr_q];
  end

  // FIFO storage, pointers and occupancy next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = in_index;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Acknowledge FSM: IDLE pops the head and enters DRIVE with the decoded ack
  // already registered; DRIVE leaves once the hold count has expired and done
  // has been seen at any point during the event.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_seen_d  = done_seen_q;
    ack_onehot_d = ack_onehot_q;
    ack_valid_d  = ack_valid_q;
    case (state_q)
      ST_IDLE: begin
        ack_onehot_d = '0;
        ack_valid_d  = 1'b0;
        if (w_pop) begin
          state_d      = ST_DRIVE;
          cnt_d        = CNT_W'(MIN_HOLD - 1);
          done_seen_d  = 1'b0;
          ack_onehot_d = OUT_W'(1) << w_head;
          ack_valid_d  = 1'b1;
        end
      end
      ST_DRIVE: begin
        if ((cnt_q == '0) && (done_seen_q || done_in)) begin
          state_d      = ST_IDLE;
          done_seen_d  = 1'b0;
          ack_onehot_d = '0;
          ack_valid_d  = 1'b0;
        end else begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          done_seen_d = done_seen_q || done_in;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        ack_onehot_d = '0;
        ack_valid_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset discards queued entries and any in-flight ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      done_seen_q  <= 1'b0;
      ack_onehot_q <= '0;
      ack_valid_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      done_seen_q  <= done_seen_d;
      ack_onehot_q <= ack_onehot_d;
      ack_valid_q  <= ack_valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Output mapping from registered state.
  always_comb begin
    ack_onehot = ack_onehot_q;
    ack_valid  = ack_valid_q;
    level      = level_q;
    busy       = (state_q != ST_IDLE) || (level_q != '0);
  end

endmodule
`default_nettype wire
